// File: rtl/fbuf_port_arbiter_if.sv
// rtl/fbuf_port_arbiter_if.sv - request, grant and BRAM port bundle for the frame-buffer arbiter
interface fbuf_port_arbiter_if #(
    parameter int RAM_WIDTH = 18,
    parameter int RAM_DEPTH = 1024
);
    localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic                 rd_req;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_gnt;
    logic                 rd_valid;
    logic [RAM_WIDTH-1:0] rd_data;

    logic                 wr_req;
    logic [ADDR_W-1:0]    wr_addr;
    logic [RAM_WIDTH-1:0] wr_data;
    logic                 wr_gnt;

    logic                 clr_start;
    logic                 clr_busy;
    logic                 clr_done;

    logic                 ram_en;
    logic                 ram_we;
    logic [ADDR_W-1:0]    ram_addr;
    logic [RAM_WIDTH-1:0] ram_din;
    logic [RAM_WIDTH-1:0] ram_dout;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, clr_start, ram_dout,
        output rd_gnt, rd_valid, rd_data, wr_gnt, clr_busy, clr_done,
               ram_en, ram_we, ram_addr, ram_din
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, clr_start, ram_dout,
        input  rd_gnt, rd_valid, rd_data, wr_gnt, clr_busy, clr_done,
               ram_en, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/fbuf_port_arbiter.sv
// rtl/fbuf_port_arbiter.sv - shares one BRAM port between display reads, writer and a clear sweep
module fbuf_port_arbiter #(
    parameter int                   RAM_WIDTH    = 18,
    parameter int                   RAM_DEPTH    = 1024,
    parameter int                   STARVE_LIMIT = 8,
    parameter logic [RAM_WIDTH-1:0] CLR_VALUE    = '0
) (
    input  logic               clka,
    input  logic               rst,
    fbuf_port_arbiter_if.slave bus
);
    localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int CNT_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(RAM_DEPTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]           state;
    logic [ADDR_W-1:0]    clr_addr;
    logic [CNT_W-1:0]     starve_cnt;
    logic                 rd_valid;
    logic                 clr_done;

    logic                 write_wins;
    logic                 rd_gnt;
    logic                 wr_gnt;
    logic                 ram_en;
    logic                 ram_we;
    logic [ADDR_W-1:0]    ram_addr;
    logic [RAM_WIDTH-1:0] ram_din;

    // Reads have priority; a waiting writer wins once it has lost STARVE_LIMIT times in a row.
    always_comb begin
        write_wins = bus.wr_req && (!bus.rd_req || (starve_cnt == STARVE_MAX));
        rd_gnt     = 1'b0;
        wr_gnt     = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = bus.rd_addr;
        ram_din    = bus.wr_data;
        if (!rst) begin
            if (state == ST_IDLE) begin
                wr_gnt   = write_wins;
                rd_gnt   = bus.rd_req && !write_wins;
                ram_en   = rd_gnt || wr_gnt;
                ram_we   = wr_gnt;
                ram_addr = write_wins ? bus.wr_addr : bus.rd_addr;
            end else begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = clr_addr;
                ram_din  = CLR_VALUE;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state      <= ST_IDLE;
            clr_addr   <= '0;
            starve_cnt <= '0;
            rd_valid   <= 1'b0;
            clr_done   <= 1'b0;
        end else begin
            rd_valid <= rd_gnt;
            clr_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (bus.clr_start) begin
                    state    <= ST_CLEAR;
                    clr_addr <= '0;
                end
                if (!bus.wr_req || wr_gnt) begin
                    starve_cnt <= '0;
                end else if (rd_gnt && (starve_cnt != STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end else begin
                // Requests stay pending and the starve count holds while sweeping.
                if (clr_addr == LAST_ADDR) begin
                    state    <= ST_IDLE;
                    clr_done <= 1'b1;
                end else begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                end
            end
        end
    end

    assign bus.rd_gnt   = rd_gnt;
    assign bus.wr_gnt   = wr_gnt;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = bus.ram_dout;
    assign bus.clr_busy = (state == ST_CLEAR);
    assign bus.clr_done = clr_done;
    assign bus.ram_en   = ram_en;
    assign bus.ram_we   = ram_we;
    assign bus.ram_addr = ram_addr;
    assign bus.ram_din  = ram_din;
endmodule

// File: doc/fbuf_port_arbiter.md
FBUF_PORT_ARBITER -- requirements
Module: fbuf_port_arbiter

Interface
REQ-001 Parameter RAM_WIDTH, default 18, pixel word width in bits.
REQ-002 Parameter RAM_DEPTH, default 1024, number of frame-buffer entries; ADDR_W = ceil(log2(RAM_DEPTH)).
REQ-003 Parameter STARVE_LIMIT, default 8, number of consecutive lost write arbitrations before a write is forced.
REQ-004 Parameter CLR_VALUE, default all-zero, RAM_WIDTH-bit word written by a clear sweep.
REQ-005 clka  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rd_req  in  1  display read request; rd_addr  in  ADDR_W  read address.
REQ-008 rd_gnt  out  1  read accepted this cycle; rd_valid  out  1  rd_data valid; rd_data  out  RAM_WIDTH  read word.
REQ-009 wr_req  in  1  writer request; wr_addr  in  ADDR_W; wr_data  in  RAM_WIDTH; wr_gnt  out  1  write accepted this cycle.
REQ-010 clr_start  in  1  start clear sweep; clr_busy  out  1  sweep in progress; clr_done  out  1  one-cycle completion pulse.
REQ-011 ram_en  out  1; ram_we  out  1; ram_addr  out  ADDR_W; ram_din  out  RAM_WIDTH; ram_dout  in  RAM_WIDTH -- single-port BRAM port, 1-cycle registered read latency.

Function
REQ-012 State machine SHALL have states IDLE and CLEAR; rd_gnt, wr_gnt, ram_* are combinational from state, requests and registers.
REQ-013 IDLE, only rd_req: rd_gnt=1, ram_en=1, ram_we=0, ram_addr=rd_addr.
REQ-014 IDLE, only wr_req: wr_gnt=1, ram_en=1, ram_we=1, ram_addr=wr_addr, ram_din=wr_data.
REQ-015 IDLE, both requests: read wins unless starve counter == STARVE_LIMIT, then write wins.
REQ-016 Starve counter: +1 each cycle wr_req=1 and read granted; cleared on any wr_gnt or any cycle wr_req=0; never exceeds STARVE_LIMIT.
REQ-017 No request (or CLEAR-state request): no grants; in IDLE ram_en=0, ram_we=0.
REQ-018 rd_valid SHALL equal rd_gnt delayed one cycle (registered); rd_data = ram_dout passthrough.
REQ-019 At most one of rd_gnt, wr_gnt asserted in any cycle; a requester holds req/addr/data stable until granted.
REQ-020 clr_start in IDLE: that cycle arbitrates normally; next cycle enter CLEAR, clr_busy=1, clear address=0.
REQ-021 CLEAR: each cycle ram_en=1, ram_we=1, ram_addr=clear address, ram_din=CLR_VALUE; address +1 per cycle.
REQ-022 After writing address RAM_DEPTH-1 (RAM_DEPTH cycles in CLEAR): return to IDLE, clr_busy=0, clr_done=1 for exactly one cycle; address never wraps.
REQ-023 clr_start while clr_busy=1 SHALL be ignored; rd_req/wr_req during CLEAR stay ungranted and pending; starve counter holds.
REQ-024 Addresses are passed through unchecked; rd_addr/wr_addr >= RAM_DEPTH is caller error.

Reset
REQ-025 rst=1: state IDLE, clear address 0, starve counter 0, rd_valid=0, clr_busy=0, clr_done=0; grants and ram_en/ram_we 0 during the reset cycle.
REQ-026 rst mid-CLEAR SHALL abort sweep with no clr_done pulse; memory contents left partially cleared.

Verification
REQ-027 rd_req=1, rd_addr=5, BRAM[5]=0x2A -> rd_gnt=1 cycle N, rd_valid=1, rd_data=0x2A cycle N+1.
REQ-028 wr_req=1, wr_addr=7, wr_data=0x155, no read -> wr_gnt=1, ram_we=1, ram_addr=7; later read of 7 returns 0x155.
REQ-029 rd_req and wr_req held high continuously, STARVE_LIMIT=8 -> 8 read grants, then wr_gnt on 9th cycle, counter 0, pattern repeats.
REQ-030 clr_start pulse, RAM_DEPTH=1024 -> clr_busy 1024 cycles, addresses 0..1023 written with CLR_VALUE, clr_done single pulse, rd_req during sweep granted first cycle after.
REQ-031 rst asserted at sweep address 300 -> next cycle IDLE, clr_busy=0, no clr_done; BRAM[0..299]=CLR_VALUE, BRAM[300..] unchanged.
REQ-032 clr_start re-pulsed mid-sweep -> ignored; total sweep still 1024 cycles, one clr_done.
